// File: rtl/conv_pkg.sv
// Shared types and constants for the 1D-convolution controller and its MAC datapath.
package conv_pkg;

   localparam int DATA_W = 14;
   localparam int ACC_W  = 28;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD_F   = 3'd1,
      ST_LOAD_X   = 3'd2,
      ST_COMPUTE  = 3'd3,
      ST_DRAIN    = 3'd4,
      ST_WAIT_OUT = 3'd5
   } ctrl_state_t;

   // Cycles from a memory-read issue to the matching accumulator enable.
   function automatic int acc_offset(input int mult_lat);
      return 2 + mult_lat;
   endfunction

endpackage

// File: rtl/mac_en_delay.sv
// Delay line turning a tap-issue pulse into the MAC stage enables.
module mac_en_delay
   import conv_pkg::*;
#(
   parameter  int MULT_LAT = 1,
   localparam int DEPTH    = acc_offset(MULT_LAT)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_issue,
   output logic             o_enable_mult,
   output logic             o_en_pipeline_reg,
   output logic             o_en_acc,
   output logic [DEPTH-1:0] o_stages
);

   logic [DEPTH-1:0] r_sr;

   // Shift the issue pulse one stage per cycle.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_sr <= '0;
      end else begin
         r_sr <= {r_sr[DEPTH-2:0], i_issue};
      end
   end

   assign o_enable_mult     = r_sr[0];
   assign o_en_pipeline_reg = r_sr[MULT_LAT];
   assign o_en_acc          = r_sr[DEPTH-1];
   assign o_stages          = r_sr;

endmodule

// File: rtl/conv1d_mac_ctrl.sv
// Load/compute sequencer for the 1D-convolution MAC: fills weight and sample
// memories from a stream, then steps the MAC through every valid-mode window.
module conv1d_mac_ctrl
   import conv_pkg::*;
#(
   parameter  int N        = 8,
   parameter  int M        = 4,
   parameter  int MULT_LAT = 1,
   localparam int FW       = (M > 1) ? $clog2(M) : 1,
   localparam int XW       = (N > 1) ? $clog2(N) : 1
) (
   input  logic          i_clk,
   input  logic          i_reset,
   input  logic          i_s_valid,
   output logic          o_s_ready,
   output logic [FW-1:0] o_addr_f,
   output logic [XW-1:0] o_addr_x,
   output logic          o_wr_en_f,
   output logic          o_wr_en_x,
   output logic          o_enable_mult,
   output logic          o_en_pipeline_reg,
   output logic          o_en_acc,
   output logic          o_clear_acc,
   output logic          o_clear_pipeline_mult,
   output logic          o_m_valid,
   input  logic          i_m_ready,
   output logic          o_done
);

   localparam int DEPTH = acc_offset(MULT_LAT);
   localparam logic [FW-1:0] TAP_LAST = FW'(M - 1);
   localparam logic [XW-1:0] F_LAST   = XW'(M - 1);
   localparam logic [XW-1:0] X_LAST   = XW'(N - 1);
   localparam logic [XW-1:0] OUT_LAST = XW'(N - M);

   ctrl_state_t r_state, w_next_state;
   logic [FW-1:0] r_tap, w_next_tap;
   logic [XW-1:0] r_out_idx, w_next_out_idx;
   logic [XW-1:0] r_load_idx, w_next_load_idx;
   logic w_issue, w_s_ready, w_clr_pipe, w_clr_acc, w_m_valid, w_done;
   logic w_wr_f, w_wr_x;
   logic [FW-1:0] w_addr_f;
   logic [XW-1:0] w_addr_x;
   logic w_en_mult, w_en_pipe, w_en_acc;
   logic [DEPTH-1:0] w_stages;

   mac_en_delay #(.MULT_LAT(MULT_LAT)) u_delay (
      .i_clk             (i_clk),
      .i_reset           (i_reset),
      .i_issue           (w_issue),
      .o_enable_mult     (w_en_mult),
      .o_en_pipeline_reg (w_en_pipe),
      .o_en_acc          (w_en_acc),
      .o_stages          (w_stages)
   );

   // State and counter registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_tap      <= '0;
         r_out_idx  <= '0;
         r_load_idx <= '0;
      end else begin
         r_state    <= w_next_state;
         r_tap      <= w_next_tap;
         r_out_idx  <= w_next_out_idx;
         r_load_idx <= w_next_load_idx;
      end
   end

   // Next-state and output decode.
   always_comb begin
      w_next_state    = r_state;
      w_next_tap      = r_tap;
      w_next_out_idx  = r_out_idx;
      w_next_load_idx = r_load_idx;
      w_issue         = 1'b0;
      w_s_ready       = 1'b0;
      w_clr_pipe      = 1'b0;
      w_clr_acc       = 1'b0;
      w_m_valid       = 1'b0;
      w_done          = 1'b0;
      w_wr_f          = 1'b0;
      w_wr_x          = 1'b0;
      w_addr_f        = '0;
      w_addr_x        = '0;
      case (r_state)
         ST_IDLE: begin
            // Clearing the accumulator here guarantees the first window starts at 0.
            w_s_ready  = 1'b1;
            w_clr_pipe = 1'b1;
            w_clr_acc  = 1'b1;
            w_wr_f     = i_s_valid;
            if (i_s_valid) begin
               if (M == 1) begin
                  w_next_state    = ST_LOAD_X;
                  w_next_load_idx = '0;
               end else begin
                  w_next_state    = ST_LOAD_F;
                  w_next_load_idx = XW'(1);
               end
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_LOAD_F: begin
            w_s_ready  = 1'b1;
            w_clr_pipe = 1'b1;
            w_addr_f   = r_load_idx[FW-1:0];
            w_wr_f     = i_s_valid;
            if (i_s_valid && (r_load_idx == F_LAST)) begin
               w_next_state    = ST_LOAD_X;
               w_next_load_idx = '0;
            end else if (i_s_valid) begin
               w_next_load_idx = r_load_idx + XW'(1);
            end else begin
               w_next_load_idx = r_load_idx;
            end
         end
         ST_LOAD_X: begin
            w_s_ready  = 1'b1;
            w_clr_pipe = 1'b1;
            w_addr_x   = r_load_idx;
            w_wr_x     = i_s_valid;
            if (i_s_valid && (r_load_idx == X_LAST)) begin
               w_next_state    = ST_COMPUTE;
               w_next_load_idx = '0;
               w_next_tap      = '0;
               w_next_out_idx  = '0;
            end else if (i_s_valid) begin
               w_next_load_idx = r_load_idx + XW'(1);
            end else begin
               w_next_load_idx = r_load_idx;
            end
         end
         ST_COMPUTE: begin
            w_issue  = 1'b1;
            w_addr_f = r_tap;
            w_addr_x = r_out_idx + XW'(r_tap);
            if (r_tap == TAP_LAST) begin
               w_next_state = ST_DRAIN;
               w_next_tap   = '0;
            end else begin
               w_next_tap = r_tap + FW'(1);
            end
         end
         ST_DRAIN: begin
            // Leave once only the final tap remains in flight, at its accumulate stage.
            if (w_stages[DEPTH-1] && (w_stages[DEPTH-2:0] == '0)) begin
               w_next_state = ST_WAIT_OUT;
            end else begin
               w_next_state = ST_DRAIN;
            end
         end
         ST_WAIT_OUT: begin
            w_m_valid = 1'b1;
            w_addr_x  = r_out_idx + XW'(1);
            if (i_m_ready && (r_out_idx < OUT_LAST)) begin
               w_clr_acc      = 1'b1;
               w_issue        = 1'b1;
               w_next_out_idx = r_out_idx + XW'(1);
               if (M == 1) begin
                  w_next_state = ST_DRAIN;
                  w_next_tap   = '0;
               end else begin
                  w_next_state = ST_COMPUTE;
                  w_next_tap   = FW'(1);
               end
            end else if (i_m_ready) begin
               w_clr_acc      = 1'b1;
               w_done         = 1'b1;
               w_next_out_idx = '0;
               w_next_state   = ST_IDLE;
            end else begin
               w_next_state = ST_WAIT_OUT;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   assign o_s_ready             = w_s_ready  & ~i_reset;
   assign o_addr_f              = i_reset ? '0 : w_addr_f;
   assign o_addr_x              = i_reset ? '0 : w_addr_x;
   assign o_wr_en_f             = w_wr_f     & ~i_reset;
   assign o_wr_en_x             = w_wr_x     & ~i_reset;
   assign o_enable_mult         = w_en_mult  & ~i_reset;
   assign o_en_pipeline_reg     = w_en_pipe  & ~i_reset;
   assign o_en_acc              = w_en_acc   & ~i_reset;
   assign o_clear_acc           = w_clr_acc  & ~i_reset;
   assign o_clear_pipeline_mult = w_clr_pipe & ~i_reset;
   assign o_m_valid             = w_m_valid  & ~i_reset;
   assign o_done                = w_done     & ~i_reset;

endmodule

// File: tb/tb_conv1d_mac_ctrl.sv
// Bench for conv1d_mac_ctrl: surrounds the controller with memories and a saturating
// MAC, and scores every output against a direct convolution of the loaded data.
module tb_conv1d_mac_ctrl;
   import conv_pkg::*;

   localparam int N  = 8;
   localparam int M  = 4;
   localparam int ML = 1;

   logic clk = 1'b0;
   logic reset, s_valid, m_ready;
   logic signed [DATA_W-1:0] s_data;
   logic s_ready, wr_en_f, wr_en_x, enable_mult, en_pipeline_reg, en_acc;
   logic clear_acc, clear_pipeline_mult, m_valid, done;
   logic [1:0] addr_f;
   logic [2:0] addr_x;

   always #5 clk = ~clk;

   conv1d_mac_ctrl #(.N(N), .M(M), .MULT_LAT(ML)) dut (
      .i_clk(clk), .i_reset(reset), .i_s_valid(s_valid), .o_s_ready(s_ready),
      .o_addr_f(addr_f), .o_addr_x(addr_x), .o_wr_en_f(wr_en_f), .o_wr_en_x(wr_en_x),
      .o_enable_mult(enable_mult), .o_en_pipeline_reg(en_pipeline_reg), .o_en_acc(en_acc),
      .o_clear_acc(clear_acc), .o_clear_pipeline_mult(clear_pipeline_mult),
      .o_m_valid(m_valid), .i_m_ready(m_ready), .o_done(done)
   );

   function automatic logic signed [ACC_W-1:0] sat(input longint v);
      longint hi, lo;
      hi = (64'sd1 <<< (ACC_W - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (ACC_W - 1));
      if (v > hi) return ACC_W'(hi);
      else if (v < lo) return ACC_W'(lo);
      else return ACC_W'(v);
   endfunction

   // External memories and MAC datapath (not reset, like the real macros).
   logic signed [DATA_W-1:0] mem_f [M];
   logic signed [DATA_W-1:0] mem_x [N];
   logic signed [DATA_W-1:0] rd_f, rd_x, mac_a, mac_b;
   logic signed [ACC_W-1:0]  mac_p, mac_f;

   always @(posedge clk) begin
      if (wr_en_f) mem_f[addr_f] <= s_data;
      if (wr_en_x) mem_x[addr_x] <= s_data;
      rd_f <= mem_f[addr_f];
      rd_x <= mem_x[addr_x];
      if (clear_pipeline_mult) begin
         mac_a <= '0; mac_b <= '0; mac_p <= '0;
      end else begin
         if (enable_mult) begin mac_a <= rd_f; mac_b <= rd_x; end
         if (en_pipeline_reg) mac_p <= mac_a * mac_b;
      end
      if (clear_acc) mac_f <= '0;
      else if (en_acc) mac_f <= sat(longint'(mac_f) + longint'(mac_p));
   end

   typedef struct { logic signed [ACC_W-1:0] f; bit last; } exp_t;
   exp_t sb[$];
   int wv[M];
   int xv[N];
   int checks = 0, errors = 0;
   int cyc = 0, wr_count = 0, hs_count = 0;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Reference: valid-mode convolution with the MAC's per-step saturation.
   task automatic push_expected();
      for (int o = 0; o <= N - M; o++) begin
         longint s = 0;
         exp_t e;
         for (int k = 0; k < M; k++) s = longint'(sat(s + longint'(wv[k]) * longint'(xv[o + k])));
         e.f = sat(s);
         e.last = (o == N - M);
         sb.push_back(e);
      end
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: scoreboard pops, latency, hold stability and idle MAC enables.
   initial begin
      bit prev_mv = 1'b0, prev_em = 1'b0, hs_valid = 1'b0;
      int em_rise = 0, hs_cyc = 0;
      logic signed [ACC_W-1:0] f_hold = '0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_mv = 1'b0; prev_em = 1'b0; hs_valid = 1'b0; hs_count = 0;
         end else begin
            if (enable_mult && !prev_em) em_rise = cyc;
            if (m_valid && !prev_mv) begin
               chk("lat_issue", cyc - em_rise, M + 1 + ML);
               if (hs_valid) chk("gap_handshake", cyc - hs_cyc, M + 2 + ML);
               f_hold = mac_f;
            end
            if (m_valid) begin
               chk("en_idle_wait", {enable_mult, en_pipeline_reg, en_acc}, 0);
               if (prev_mv) chk("f_stable", mac_f, f_hold);
            end
            if (done && !(m_valid && m_ready)) chk("done_spurious", done, 0);
            if (m_valid && m_ready) begin
               if (sb.size() == 0) begin
                  chk("sb_underflow", 0, 1);
               end else begin
                  e = sb.pop_front();
                  chk("f", mac_f, e.f);
                  chk("done", done, e.last);
               end
               hs_cyc = cyc;
               hs_valid = !done;
               hs_count = done ? 0 : hs_count + 1;
            end
            if (wr_en_f || wr_en_x) wr_count++;
            prev_mv = m_valid;
            prev_em = enable_mult;
         end
      end
   end

   task automatic reset_check();
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("rst_outs_zero", {s_ready, addr_f, addr_x, wr_en_f, wr_en_x, enable_mult, en_pipeline_reg,
                            en_acc, clear_acc, clear_pipeline_mult, m_valid, done}, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("post_rst_idle", {s_ready, clear_pipeline_mult, m_valid, done, enable_mult,
                            en_pipeline_reg, en_acc, wr_en_f, wr_en_x}, 9'b110000000);
      sb.delete();
   endtask

   task automatic load_words(input bit bursty);
      int k = 0, g = 0;
      wr_count = 0;
      while (k < M + N && g < 200) begin
         @(posedge clk); #1;
         if (bursty && (g % 2 == 1)) begin
            s_valid = 1'b0; s_data = DATA_W'($urandom);
         end else begin
            s_valid = 1'b1; s_data = DATA_W'((k < M) ? wv[k] : xv[k - M]);
         end
         @(negedge clk);
         if (s_valid && s_ready) k++;
         g++;
      end
      @(posedge clk); #1 s_valid = 1'b0;
      if (k != M + N) chk("load_timeout", k, M + N);
      chk("load_writes", wr_count, M + N);
      for (int i = 0; i < M; i++) chk("mem_f", mem_f[i], wv[i]);
      for (int i = 0; i < N; i++) chk("mem_x", mem_x[i], xv[i]);
   endtask

   // mode 0: m_ready high, 1: random, 2: hold low 5 cycles on output 2.
   task automatic finish_outputs(input int mode);
      int g = 0, bp = 0;
      bit fin = 1'b0;
      while (!fin && g < 2000) begin
         @(posedge clk); #1;
         s_valid = 1'($urandom);
         s_data  = DATA_W'($urandom);
         if (mode == 1) m_ready = 1'($urandom);
         else if (mode == 2 && m_valid && hs_count == 1 && bp < 5) begin m_ready = 1'b0; bp++; end
         else m_ready = 1'b1;
         @(negedge clk);
         if (done && m_valid && m_ready) fin = 1'b1;
         g++;
      end
      @(posedge clk); #1 s_valid = 1'b0; m_ready = 1'b1;
      if (!fin) chk("run_timeout", fin, 1);
      chk("sb_drained", sb.size(), 0);
      chk("total_writes", wr_count, M + N);
      @(negedge clk);
      chk("idle_after_done", {s_ready, m_valid}, 2'b10);
   endtask

   task automatic set_basic();
      for (int i = 0; i < M; i++) wv[i] = i + 1;
      for (int i = 0; i < N; i++) xv[i] = i + 1;
   endtask

   task automatic run(input bit bursty, input int mode);
      push_expected();
      load_words(bursty);
      finish_outputs(mode);
   endtask

   initial begin
      int g;
      reset = 1'b1; s_valid = 1'b0; m_ready = 1'b1; s_data = '0;
      repeat (2) @(posedge clk);
      reset_check();

      set_basic();
      run(1'b0, 0);
      run(1'b0, 2);

      for (int i = 0; i < M; i++) wv[i] = 8191;
      for (int i = 0; i < N; i++) xv[i] = 8191;
      run(1'b0, 0);
      for (int i = 0; i < M; i++) wv[i] = -8192;
      run(1'b0, 0);

      set_basic();
      run(1'b1, 0);

      // Abort the first window mid-accumulation, then reload.
      for (int i = 0; i < M; i++) wv[i] = 100 + i;
      for (int i = 0; i < N; i++) xv[i] = 50 - i;
      push_expected();
      load_words(1'b0);
      g = 0;
      while (!enable_mult && g < 50) begin @(negedge clk); g++; end
      chk("abort_started", enable_mult, 1);
      repeat (2) @(negedge clk);
      reset_check();
      set_basic();
      run(1'b0, 0);

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < M; i++) wv[i] = int'($urandom_range(16383)) - 8192;
         for (int i = 0; i < N; i++) xv[i] = int'($urandom_range(16383)) - 8192;
         run(1'($urandom), 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
